// File: rtl/reg_bus_arbiter.sv
// Round-robin owner selection for one shared 4-bit tri-state bus feeding four register slices.
// Each transfer runs GRANT -> XFER -> TURN, so two slices never drive the bus together.
module reg_bus_arbiter #(
    parameter int XFER_CYC = 2,
    parameter int TURN_CYC = 1
) (
    input  logic       i_clk,
    input  logic       i_clr,
    input  logic [3:0] i_req,
    input  logic [3:0] i_wr,
    output logic [3:0] o_gnt,
    output logic [3:0] o_oe,
    output logic [3:0] o_ld,
    output logic [1:0] o_cur,
    output logic       o_busy,
    output logic [1:0] o_state
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_XFER  = 2'd2;
    localparam logic [1:0] S_TURN  = 2'd3;

    localparam logic [3:0] XFER_LAST = 4'(XFER_CYC - 1);
    localparam logic [3:0] TURN_LAST = 4'(TURN_CYC - 1);

    logic [1:0] r_state;
    logic [3:0] r_cnt;
    logic [1:0] r_ptr;
    logic       r_dir;
    logic [3:0] r_gnt;
    logic [3:0] r_oe;
    logic [3:0] r_ld;
    logic [1:0] r_cur;
    logic       r_busy;

    logic [1:0] w_win;
    logic       w_any;
    logic [3:0] w_win_oh;
    logic [3:0] w_cur_oh;

    // Search starts one past the last owner and wraps, so the last owner has lowest priority.
    always_comb begin
        logic [1:0] idx;
        w_win = r_ptr;
        w_any = 1'b0;
        idx   = r_ptr;
        for (int k = 1; k < 5; k++) begin
            idx = r_ptr + 2'(k);
            if (!w_any && i_req[idx]) begin
                w_win = idx;
                w_any = 1'b1;
            end
        end
    end

    assign w_win_oh = 4'b0001 << w_win;
    assign w_cur_oh = 4'b0001 << r_cur;

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_ptr   <= 2'd3;
            r_dir   <= 1'b0;
            r_gnt   <= 4'b0000;
            r_oe    <= 4'b1111;
            r_ld    <= 4'b0000;
            r_cur   <= 2'd0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_state <= S_GRANT;
                        r_gnt   <= w_win_oh;
                        r_cur   <= w_win;
                        r_ptr   <= w_win;
                        r_dir   <= i_wr[w_win];
                        r_busy  <= 1'b1;
                    end
                end
                S_GRANT: begin
                    r_state <= S_XFER;
                    r_cnt   <= 4'd0;
                    if (!r_dir) begin
                        r_oe <= ~w_cur_oh;
                    end else if (XFER_LAST == 4'd0) begin
                        r_ld <= w_cur_oh;
                    end
                end
                S_XFER: begin
                    if (r_cnt == XFER_LAST) begin
                        r_state <= S_TURN;
                        r_cnt   <= 4'd0;
                        r_gnt   <= 4'b0000;
                        r_oe    <= 4'b1111;
                        r_ld    <= 4'b0000;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                        // The load strobe lands only on the final XFER cycle.
                        if (r_dir && (r_cnt + 4'd1 == XFER_LAST)) begin
                            r_ld <= w_cur_oh;
                        end
                    end
                end
                S_TURN: begin
                    if (r_cnt == TURN_LAST) begin
                        r_cnt <= 4'd0;
                        if (w_any) begin
                            r_state <= S_GRANT;
                            r_gnt   <= w_win_oh;
                            r_cur   <= w_win;
                            r_ptr   <= w_win;
                            r_dir   <= i_wr[w_win];
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_gnt   = r_gnt;
    assign o_oe    = r_oe;
    assign o_ld    = r_ld;
    assign o_cur   = r_cur;
    assign o_busy  = r_busy;
    assign o_state = r_state;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Directed per-cycle vectors for reg_bus_arbiter; expected outputs are queued by the driver
// and checked by an independent negedge monitor together with the bus-safety invariants.
module tb_reg_bus_arbiter;

    localparam int W = 17;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_XFER  = 2'd2;
    localparam logic [1:0] S_TURN  = 2'd3;

    logic       clk;
    logic       clr;
    logic [3:0] req;
    logic [3:0] wr;
    logic [3:0] gnt;
    logic [3:0] oe;
    logic [3:0] ld;
    logic [1:0] cur;
    logic       busy;
    logic [1:0] state;

    logic [W-1:0] exp_q[$];
    int n_assert;
    int n_fail;
    int cyc;

    reg_bus_arbiter #(.XFER_CYC(2), .TURN_CYC(1)) dut (
        .i_clk(clk), .i_clr(clr), .i_req(req), .i_wr(wr),
        .o_gnt(gnt), .o_oe(oe), .o_ld(ld), .o_cur(cur), .o_busy(busy), .o_state(state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_assert++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp_v);
        end
    endtask

    // One cycle: drive inputs for this cycle and queue the outputs expected during it.
    task automatic vec(input logic [3:0] r, input logic [3:0] w, input logic c,
                       input logic [3:0] e_gnt, input logic [3:0] e_oe, input logic [3:0] e_ld,
                       input logic [1:0] e_cur, input logic e_busy, input logic [1:0] e_st);
        @(posedge clk);
        #1;
        req = r;
        wr  = w;
        clr = c;
        exp_q.push_back({e_gnt, e_oe, e_ld, e_cur, e_busy, e_st});
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        logic [W-1:0] e;
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("gnt",   32'(gnt),   32'(e[16:13]));
            chk("oe",    32'(oe),    32'(e[12:9]));
            chk("ld",    32'(ld),    32'(e[8:5]));
            chk("cur",   32'(cur),   32'(e[4:3]));
            chk("busy",  32'(busy),  32'(e[2]));
            chk("state", 32'(state), 32'(e[1:0]));
            chk("inv_oe_one_low",  32'($countones(~oe) <= 1), 32'd1);
            chk("inv_gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
            chk("inv_ld_vs_drive", 32'(ld & ~oe), 32'd0);
        end
    end

    initial begin
        logic [3:0] oh;
        logic [3:0] rq;
        n_assert = 0;
        n_fail   = 0;
        cyc      = 0;
        clr = 1'b1;
        req = 4'b0000;
        wr  = 4'b0000;
        repeat (2) @(posedge clk);

        // reset state
        vec(4'h0, 4'h0, 1'b1, 4'h0, 4'hF, 4'h0, 2'd0, 1'b0, S_IDLE);

        // single read of slice 0
        vec(4'h1, 4'h0, 1'b0, 4'h0, 4'hF, 4'h0, 2'd0, 1'b0, S_IDLE);
        vec(4'h0, 4'h0, 1'b0, 4'h1, 4'hF, 4'h0, 2'd0, 1'b1, S_GRANT);
        vec(4'h0, 4'h0, 1'b0, 4'h1, 4'hE, 4'h0, 2'd0, 1'b1, S_XFER);
        vec(4'h0, 4'h0, 1'b0, 4'h1, 4'hE, 4'h0, 2'd0, 1'b1, S_XFER);
        vec(4'h0, 4'h0, 1'b0, 4'h0, 4'hF, 4'h0, 2'd0, 1'b1, S_TURN);
        vec(4'h0, 4'h0, 1'b0, 4'h0, 4'hF, 4'h0, 2'd0, 1'b0, S_IDLE);

        // single write into slice 2
        vec(4'h4, 4'h4, 1'b0, 4'h0, 4'hF, 4'h0, 2'd0, 1'b0, S_IDLE);
        vec(4'h0, 4'h0, 1'b0, 4'h4, 4'hF, 4'h0, 2'd2, 1'b1, S_GRANT);
        vec(4'h0, 4'h0, 1'b0, 4'h4, 4'hF, 4'h0, 2'd2, 1'b1, S_XFER);
        vec(4'h0, 4'h0, 1'b0, 4'h4, 4'hF, 4'h4, 2'd2, 1'b1, S_XFER);
        vec(4'h0, 4'h0, 1'b0, 4'h0, 4'hF, 4'h0, 2'd2, 1'b1, S_TURN);
        vec(4'h0, 4'h0, 1'b0, 4'h0, 4'hF, 4'h0, 2'd2, 1'b0, S_IDLE);

        // wrap: ptr=2, REQ=1001 -> slice 3 then slice 0 back to back
        vec(4'h9, 4'h0, 1'b0, 4'h0, 4'hF, 4'h0, 2'd2, 1'b0, S_IDLE);
        vec(4'h9, 4'h0, 1'b0, 4'h8, 4'hF, 4'h0, 2'd3, 1'b1, S_GRANT);
        vec(4'h9, 4'h0, 1'b0, 4'h8, 4'h7, 4'h0, 2'd3, 1'b1, S_XFER);
        vec(4'h9, 4'h0, 1'b0, 4'h8, 4'h7, 4'h0, 2'd3, 1'b1, S_XFER);
        vec(4'h1, 4'h0, 1'b0, 4'h0, 4'hF, 4'h0, 2'd3, 1'b1, S_TURN);
        vec(4'h0, 4'h0, 1'b0, 4'h1, 4'hF, 4'h0, 2'd0, 1'b1, S_GRANT);
        vec(4'h0, 4'h0, 1'b0, 4'h1, 4'hE, 4'h0, 2'd0, 1'b1, S_XFER);
        vec(4'h0, 4'h0, 1'b0, 4'h1, 4'hE, 4'h0, 2'd0, 1'b1, S_XFER);
        vec(4'h0, 4'h0, 1'b0, 4'h0, 4'hF, 4'h0, 2'd0, 1'b1, S_TURN);
        vec(4'h0, 4'h0, 1'b0, 4'h0, 4'hF, 4'h0, 2'd0, 1'b0, S_IDLE);

        // full round-robin from reset with all requesters active
        vec(4'h0, 4'h0, 1'b1, 4'h0, 4'hF, 4'h0, 2'd0, 1'b0, S_IDLE);
        vec(4'hF, 4'h0, 1'b0, 4'h0, 4'hF, 4'h0, 2'd0, 1'b0, S_IDLE);
        for (int s = 0; s < 5; s++) begin
            oh = 4'b0001 << (s % 4);
            rq = (s < 4) ? 4'hF : 4'h0;
            vec(rq, 4'h0, 1'b0, oh,    4'hF, 4'h0, 2'(s % 4), 1'b1, S_GRANT);
            vec(rq, 4'h0, 1'b0, oh,    ~oh,  4'h0, 2'(s % 4), 1'b1, S_XFER);
            vec(rq, 4'h0, 1'b0, oh,    ~oh,  4'h0, 2'(s % 4), 1'b1, S_XFER);
            vec(rq, 4'h0, 1'b0, 4'h0,  4'hF, 4'h0, 2'(s % 4), 1'b1, S_TURN);
        end
        vec(4'h0, 4'h0, 1'b0, 4'h0, 4'hF, 4'h0, 2'd0, 1'b0, S_IDLE);

        // reset during the 2nd XFER cycle of a write to slice 2
        vec(4'h4, 4'h4, 1'b0, 4'h0, 4'hF, 4'h0, 2'd0, 1'b0, S_IDLE);
        vec(4'h0, 4'h0, 1'b0, 4'h4, 4'hF, 4'h0, 2'd2, 1'b1, S_GRANT);
        vec(4'h0, 4'h0, 1'b0, 4'h4, 4'hF, 4'h0, 2'd2, 1'b1, S_XFER);
        vec(4'h0, 4'h0, 1'b1, 4'h4, 4'hF, 4'h4, 2'd2, 1'b1, S_XFER);
        vec(4'h2, 4'h0, 1'b0, 4'h0, 4'hF, 4'h0, 2'd0, 1'b0, S_IDLE);
        vec(4'h0, 4'h0, 1'b0, 4'h2, 4'hF, 4'h0, 2'd1, 1'b1, S_GRANT);
        vec(4'h0, 4'h0, 1'b0, 4'h2, 4'hD, 4'h0, 2'd1, 1'b1, S_XFER);
        vec(4'h0, 4'h0, 1'b0, 4'h2, 4'hD, 4'h0, 2'd1, 1'b1, S_XFER);
        vec(4'h0, 4'h0, 1'b0, 4'h0, 4'hF, 4'h0, 2'd1, 1'b1, S_TURN);
        vec(4'h0, 4'h0, 1'b0, 4'h0, 4'hF, 4'h0, 2'd1, 1'b0, S_IDLE);

        // late REQ change: slice 0 completes, slice 1 wins at TURN exit
        vec(4'h1, 4'h0, 1'b0, 4'h0, 4'hF, 4'h0, 2'd1, 1'b0, S_IDLE);
        vec(4'h1, 4'h0, 1'b0, 4'h1, 4'hF, 4'h0, 2'd0, 1'b1, S_GRANT);
        vec(4'h2, 4'h2, 1'b0, 4'h1, 4'hE, 4'h0, 2'd0, 1'b1, S_XFER);
        vec(4'h2, 4'h0, 1'b0, 4'h1, 4'hE, 4'h0, 2'd0, 1'b1, S_XFER);
        vec(4'h2, 4'h0, 1'b0, 4'h0, 4'hF, 4'h0, 2'd0, 1'b1, S_TURN);
        vec(4'h0, 4'h0, 1'b0, 4'h2, 4'hF, 4'h0, 2'd1, 1'b1, S_GRANT);
        vec(4'h0, 4'h0, 1'b0, 4'h2, 4'hD, 4'h0, 2'd1, 1'b1, S_XFER);
        vec(4'h0, 4'h0, 1'b0, 4'h2, 4'hD, 4'h0, 2'd1, 1'b1, S_XFER);
        vec(4'h0, 4'h0, 1'b0, 4'h0, 4'hF, 4'h0, 2'd1, 1'b1, S_TURN);
        vec(4'h0, 4'h0, 1'b0, 4'h0, 4'hF, 4'h0, 2'd1, 1'b0, S_IDLE);

        // drain the scoreboard
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("queue_drain", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
